// File: rtl/ls_port_arbiter_if.sv
// Bundle of SPU pipe, DMA engine and local-store port signals around the LS port arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface ls_port_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned QW     = 128
);
   logic              spu_req;
   logic              spu_we;
   logic [ADDR_W-1:0] spu_addr;
   logic [QW-1:0]     spu_wdata;
   logic              spu_gnt;
   logic              spu_rvalid;
   logic [QW-1:0]     spu_rdata;

   logic              dma_cmd_valid;
   logic              dma_cmd_ready;
   logic              dma_cmd_we;
   logic [ADDR_W-1:0] dma_cmd_addr;
   logic [3:0]        dma_cmd_len;
   logic              dma_wvalid;
   logic [QW-1:0]     dma_wdata;
   logic              dma_wready;
   logic              dma_rvalid;
   logic [QW-1:0]     dma_rdata;
   logic              dma_done;

   logic              ls_en;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [QW-1:0]     ls_wdata;
   logic              ls_rvalid;
   logic [QW-1:0]     ls_rdata;

   modport slave (
      input  spu_req, spu_we, spu_addr, spu_wdata,
      output spu_gnt, spu_rvalid, spu_rdata,
      input  dma_cmd_valid, dma_cmd_we, dma_cmd_addr, dma_cmd_len, dma_wvalid, dma_wdata,
      output dma_cmd_ready, dma_wready, dma_rvalid, dma_rdata, dma_done,
      output ls_en, ls_we, ls_addr, ls_wdata,
      input  ls_rvalid, ls_rdata
   );

   modport master (
      output spu_req, spu_we, spu_addr, spu_wdata,
      input  spu_gnt, spu_rvalid, spu_rdata,
      output dma_cmd_valid, dma_cmd_we, dma_cmd_addr, dma_cmd_len, dma_wvalid, dma_wdata,
      input  dma_cmd_ready, dma_wready, dma_rvalid, dma_rdata, dma_done,
      input  ls_en, ls_we, ls_addr, ls_wdata,
      output ls_rvalid, ls_rdata
   );
endinterface

// File: rtl/ls_port_arbiter.sv
// Shares the local-store port between SPU single-quadword accesses and DMA bursts,
// and steers returning read data to its owner via an issue-ordered owner pipe.
module ls_port_arbiter #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned QW         = 128,
   parameter int unsigned RD_LAT     = 6,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic              clk,
   input logic              reset,
   ls_port_arbiter_if.slave bus_io
);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e            state_q, state_d;
   logic              burst_we_q, burst_we_d;
   logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
   logic [3:0]        len_q, len_d;
   logic [3:0]        beat_q, beat_d;
   logic              done_q, done_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              ls_en_q, ls_en_d;
   logic              ls_we_q, ls_we_d;
   logic              ls_own_q, ls_own_d;
   logic [ADDR_W-1:0] ls_addr_q, ls_addr_d;
   logic [QW-1:0]     ls_wdata_q, ls_wdata_d;
   logic [RD_LAT-1:0] rd_v_q, rd_v_d;
   logic [RD_LAT-1:0] rd_own_q, rd_own_d;

   logic cmd_ready, pending, cmd_fire, last_beat, spu_win, dma_win;
   logic spu_rv, dma_rv;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cmd_fire) state_d = StBurst;
         StBurst: if (dma_win && last_beat) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      cmd_ready = 1'b0;
      pending   = 1'b0;
      unique case (state_q)
         StIdle:  cmd_ready = !reset;
         StBurst: pending   = !burst_we_q || bus_io.dma_wvalid;
         default: ;
      endcase
   end

   assign cmd_fire  = bus_io.dma_cmd_valid && cmd_ready;
   assign last_beat = (beat_q == len_q);
   assign spu_win   = !reset && bus_io.spu_req && !(pending && starve_q == SW'(STARVE_MAX));
   assign dma_win   = !reset && pending && !spu_win;

   always_comb begin
      burst_we_d   = burst_we_q;
      burst_addr_d = burst_addr_q;
      len_d        = len_q;
      beat_d       = beat_q;
      done_d       = dma_win && last_beat;
      starve_d     = starve_q;
      if (cmd_fire) begin
         burst_we_d   = bus_io.dma_cmd_we;
         burst_addr_d = {bus_io.dma_cmd_addr[ADDR_W-1:4], 4'b0};
         len_d        = bus_io.dma_cmd_len;
         beat_d       = 4'd0;
      end else if (dma_win) begin
         burst_addr_d = burst_addr_q + ADDR_W'(16);
         beat_d       = beat_q + 4'd1;
      end
      if (dma_win)                                     starve_d = '0;
      else if (pending && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);

      ls_en_d    = spu_win || dma_win;
      ls_we_d    = ls_we_q;
      ls_own_d   = ls_own_q;
      ls_addr_d  = ls_addr_q;
      ls_wdata_d = ls_wdata_q;
      if (spu_win) begin
         ls_we_d    = bus_io.spu_we;
         ls_own_d   = 1'b0;
         ls_addr_d  = {bus_io.spu_addr[ADDR_W-1:4], 4'b0};
         ls_wdata_d = bus_io.spu_wdata;
      end else if (dma_win) begin
         ls_we_d    = burst_we_q;
         ls_own_d   = 1'b1;
         ls_addr_d  = burst_addr_q;
         ls_wdata_d = bus_io.dma_wdata;
      end

      // Owner pipe: entry enters as the read appears on the LS port, tail aligns with rvalid
      rd_v_d   = {rd_v_q[RD_LAT-2:0], ls_en_q & ~ls_we_q};
      rd_own_d = {rd_own_q[RD_LAT-2:0], ls_own_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         burst_we_q   <= 1'b0;
         burst_addr_q <= '0;
         len_q        <= '0;
         beat_q       <= '0;
         done_q       <= 1'b0;
         starve_q     <= '0;
         ls_en_q      <= 1'b0;
         ls_we_q      <= 1'b0;
         ls_own_q     <= 1'b0;
         ls_addr_q    <= '0;
         ls_wdata_q   <= '0;
         rd_v_q       <= '0;
         rd_own_q     <= '0;
      end else begin
         burst_we_q   <= burst_we_d;
         burst_addr_q <= burst_addr_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         done_q       <= done_d;
         starve_q     <= starve_d;
         ls_en_q      <= ls_en_d;
         ls_we_q      <= ls_we_d;
         ls_own_q     <= ls_own_d;
         ls_addr_q    <= ls_addr_d;
         ls_wdata_q   <= ls_wdata_d;
         rd_v_q       <= rd_v_d;
         rd_own_q     <= rd_own_d;
      end
   end

   assign spu_rv = !reset && bus_io.ls_rvalid && rd_v_q[RD_LAT-1] && !rd_own_q[RD_LAT-1];
   assign dma_rv = !reset && bus_io.ls_rvalid && rd_v_q[RD_LAT-1] && rd_own_q[RD_LAT-1];

   assign bus_io.spu_gnt       = spu_win;
   assign bus_io.spu_rvalid    = spu_rv;
   assign bus_io.spu_rdata     = spu_rv ? bus_io.ls_rdata : '0;
   assign bus_io.dma_cmd_ready = cmd_ready;
   assign bus_io.dma_wready    = dma_win && burst_we_q;
   assign bus_io.dma_rvalid    = dma_rv;
   assign bus_io.dma_rdata     = dma_rv ? bus_io.ls_rdata : '0;
   assign bus_io.dma_done      = done_q;
   assign bus_io.ls_en         = ls_en_q;
   assign bus_io.ls_we         = ls_we_q;
   assign bus_io.ls_addr       = ls_addr_q;
   assign bus_io.ls_wdata      = ls_wdata_q;
endmodule

// File: tb/tb_ls_port_arbiter.sv
// Randomized and directed bench for ls_port_arbiter against a transaction-level model
// with a fixed-latency local-store responder.
module tb_ls_port_arbiter;
   localparam int RD   = 6;
   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;

   ls_port_arbiter_if #(.ADDR_W(8), .QW(128)) bus ();

   ls_port_arbiter #(.ADDR_W(8), .QW(128), .RD_LAT(RD), .STARVE_MAX(SMAX)) dut (
      .clk    (clk),
      .reset  (rst),
      .bus_io (bus)
   );

   function automatic logic [127:0] lsdata(logic [7:0] a, int c);
      return {24'hC0FFEE, a, 32'(c), 32'(c) ^ 32'h5A5A_5A5A, 24'h0, a};
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   // LS responder: each read seen on the port returns RD cycles later
   bit        resp_v[32];
   logic [7:0] resp_a[32];
   int        resp_c[32];

   initial begin
      bus.ls_rvalid = 1'b0;
      bus.ls_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         bus.ls_rvalid = resp_v[cyc % 32];
         bus.ls_rdata  = resp_v[cyc % 32] ? lsdata(resp_a[cyc % 32], resp_c[cyc % 32]) : '0;
         resp_v[cyc % 32] = 1'b0;
      end
   end

   // Transaction model
   bit         m_init = 0;
   bit         m_busy, m_bwe, m_done, m_en, m_we;
   logic [7:0] m_baddr, m_addr;
   int         m_left, m_starve;
   logic [127:0] m_wd;
   bit         ev[32];
   bit         eown[32];
   logic [7:0] eaddr[32];

   always @(negedge clk) begin
      bit pend, sw, dw, accept, ev_now, own_now;
      logic [7:0] ea_now;
      pend    = m_busy && (!m_bwe || bus.dma_wvalid);
      sw      = !rst && bus.spu_req && !(pend && m_starve == SMAX);
      dw      = !rst && pend && !sw;
      ev_now  = ev[cyc % 32] && !rst;
      own_now = eown[cyc % 32];
      ea_now  = eaddr[cyc % 32];
      ev[cyc % 32] = 1'b0;
      if (m_init) begin
         chk("spu_gnt", bus.spu_gnt, sw);
         chk("dma_wready", bus.dma_wready, dw && m_bwe);
         chk("dma_cmd_ready", bus.dma_cmd_ready, !rst && !m_busy);
         chk("dma_done", bus.dma_done, m_done);
         chk("ls_en", bus.ls_en, m_en);
         chk("ls_we", bus.ls_we, m_we);
         chk("ls_addr", bus.ls_addr, m_addr);
         if (m_en && m_we) chk("ls_wdata", bus.ls_wdata, m_wd);
         chk("spu_rvalid", bus.spu_rvalid, ev_now && !own_now);
         chk("dma_rvalid", bus.dma_rvalid, ev_now && own_now);
         chk("spu_rdata", bus.spu_rdata, (ev_now && !own_now) ? lsdata(ea_now, cyc - RD) : '0);
         chk("dma_rdata", bus.dma_rdata, (ev_now && own_now) ? lsdata(ea_now, cyc - RD) : '0);
      end
      if (bus.ls_en && !bus.ls_we) begin
         resp_v[(cyc + RD) % 32] = 1'b1;
         resp_a[(cyc + RD) % 32] = bus.ls_addr;
         resp_c[(cyc + RD) % 32] = cyc;
      end
      if (rst) begin
         m_init = 1; m_busy = 0; m_bwe = 0; m_done = 0; m_en = 0; m_we = 0;
         m_baddr = 0; m_addr = 0; m_left = 0; m_starve = 0; m_wd = '0;
         for (int i = 0; i < 32; i++) ev[i] = 1'b0;
      end else begin
         accept = !m_busy && bus.dma_cmd_valid;
         m_en   = sw || dw;
         if (sw) begin
            m_we = bus.spu_we; m_addr = bus.spu_addr & 8'hF0; m_wd = bus.spu_wdata;
         end else if (dw) begin
            m_we = m_bwe; m_addr = m_baddr; m_wd = bus.dma_wdata;
         end
         if (m_en && !m_we) begin
            ev[(cyc + 1 + RD) % 32]    = 1'b1;
            eown[(cyc + 1 + RD) % 32]  = dw;
            eaddr[(cyc + 1 + RD) % 32] = m_addr;
         end
         m_done = dw && m_left == 1;
         if (dw) m_starve = 0;
         else if (pend && m_starve < SMAX) m_starve++;
         if (dw) begin
            m_baddr = m_baddr + 8'd16;
            m_left--;
            if (m_left == 0) m_busy = 0;
         end else if (accept) begin
            m_busy = 1; m_bwe = bus.dma_cmd_we;
            m_baddr = bus.dma_cmd_addr & 8'hF0; m_left = int'(bus.dma_cmd_len) + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] ea[4];
   bit last_gnt, last_ready;

   initial begin
      rst = 1'b1;
      bus.spu_req = 0; bus.spu_we = 0; bus.spu_addr = 0; bus.spu_wdata = '0;
      bus.dma_cmd_valid = 0; bus.dma_cmd_we = 0; bus.dma_cmd_addr = 0; bus.dma_cmd_len = 0;
      bus.dma_wvalid = 0; bus.dma_wdata = '0;
      repeat (3) step();
      rst = 1'b0;

      repeat (10) step();
      @(negedge clk);
      chk("idle_ls_en", bus.ls_en, 1'b0);
      chk("idle_cmd_ready", bus.dma_cmd_ready, 1'b1);
      step();

      // SPU load from 0x23
      bus.spu_req = 1; bus.spu_we = 0; bus.spu_addr = 8'h23;
      @(negedge clk);
      chk("spu_ld_gnt", bus.spu_gnt, 1'b1);
      step();
      bus.spu_req = 0;
      @(negedge clk);
      chk("spu_ld_en", bus.ls_en, 1'b1);
      chk("spu_ld_we", bus.ls_we, 1'b0);
      chk("spu_ld_addr", bus.ls_addr, 8'h20);
      step();
      repeat (RD - 1) step();
      @(negedge clk);
      chk("spu_ld_rvalid", bus.spu_rvalid, 1'b1);
      chk("spu_ld_no_dma", bus.dma_rvalid, 1'b0);
      step();

      // DMA read burst wrapping past the top of LS
      ea[0] = 8'hE0; ea[1] = 8'hF0; ea[2] = 8'h00; ea[3] = 8'h10;
      bus.dma_cmd_valid = 1; bus.dma_cmd_we = 0; bus.dma_cmd_addr = 8'hE0; bus.dma_cmd_len = 3;
      step();
      bus.dma_cmd_valid = 0;
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("dma_rd_en", bus.ls_en, 1'b1);
         chk("dma_rd_addr", bus.ls_addr, ea[i]);
         if (i == 3) chk("dma_rd_done", bus.dma_done, 1'b1);
         step();
      end
      repeat (2) step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("dma_rd_rvalid", bus.dma_rvalid, 1'b1);
         chk("dma_rd_no_spu", bus.spu_rvalid, 1'b0);
         step();
      end

      // DMA write burst against a continuously requesting SPU
      bus.dma_cmd_valid = 1; bus.dma_cmd_we = 1; bus.dma_cmd_addr = 8'h40; bus.dma_cmd_len = 1;
      bus.dma_wvalid = 1; bus.dma_wdata = {4{$urandom}};
      step();
      bus.dma_cmd_valid = 0;
      bus.spu_req = 1; bus.spu_we = 1; bus.spu_addr = 8'h80; bus.spu_wdata = {4{$urandom}};
      for (int k = 1; k <= 10; k++) begin
         bus.dma_wdata = {4{$urandom}};
         @(negedge clk);
         chk("starve_wready", bus.dma_wready, (k == 5 || k == 10));
         chk("starve_spu_gnt", bus.spu_gnt, !(k == 5 || k == 10));
         step();
      end
      bus.spu_req = 0; bus.dma_wvalid = 0;

      // SPU read then DMA read: responses must not cross
      bus.dma_cmd_valid = 1; bus.dma_cmd_we = 0; bus.dma_cmd_addr = 8'h60; bus.dma_cmd_len = 0;
      bus.spu_req = 1; bus.spu_we = 0; bus.spu_addr = 8'h55;
      @(negedge clk);
      chk("mix_spu_gnt", bus.spu_gnt, 1'b1);
      step();
      bus.dma_cmd_valid = 0; bus.spu_req = 0;
      step();
      repeat (5) step();
      @(negedge clk);
      chk("mix_spu_first", bus.spu_rvalid, 1'b1);
      chk("mix_dma_not_first", bus.dma_rvalid, 1'b0);
      step();
      @(negedge clk);
      chk("mix_dma_second", bus.dma_rvalid, 1'b1);
      chk("mix_spu_not_second", bus.spu_rvalid, 1'b0);
      step();

      // Reset in the middle of a 16-beat read burst
      bus.dma_cmd_valid = 1; bus.dma_cmd_we = 0; bus.dma_cmd_addr = 8'h00; bus.dma_cmd_len = 15;
      step();
      bus.dma_cmd_valid = 0;
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ls_en", bus.ls_en, 1'b0);
      chk("rst_cmd_ready", bus.dma_cmd_ready, 1'b1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("rst_no_done", bus.dma_done, 1'b0);
         chk("rst_no_rvalid", bus.dma_rvalid, 1'b0);
         step();
      end

      // Random traffic
      last_gnt = 0; last_ready = 0;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         if (!bus.spu_req || last_gnt) begin
            bus.spu_req   = ($urandom_range(0, 2) != 0);
            bus.spu_we    = $urandom_range(0, 1);
            bus.spu_addr  = 8'($urandom);
            bus.spu_wdata = {4{$urandom}};
         end
         if (!bus.dma_cmd_valid || last_ready) begin
            bus.dma_cmd_valid = ($urandom_range(0, 5) == 0);
            bus.dma_cmd_we    = $urandom_range(0, 1);
            bus.dma_cmd_addr  = 8'($urandom);
            bus.dma_cmd_len   = 4'($urandom);
         end
         bus.dma_wvalid = $urandom_range(0, 1);
         bus.dma_wdata  = {4{$urandom}};
         @(negedge clk);
         last_gnt   = bus.spu_gnt;
         last_ready = bus.dma_cmd_ready;
         step();
      end
      rst = 0; bus.spu_req = 0; bus.dma_cmd_valid = 0; bus.dma_wvalid = 0;
      repeat (40) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
